// File: rtl/ldm_stm_seq.sv
// Load/store-multiple sequencer: turns a register list and base into single-word beats.
// Optional base writeback is built only when LDM_STM_SEQ_WB_EN is defined.
module ldm_stm_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        load_i,
  input  logic        up_i,
  input  logic        pre_i,
  input  logic        wb_i,
  input  logic [3:0]  base_reg_i,
  input  logic [31:0] base_i,
  input  logic [15:0] reg_list_i,
  output logic        busy_o,
  output logic        beat_valid_o,
  input  logic        beat_ready_i,
  output logic [3:0]  beat_reg_o,
  output logic [31:0] beat_addr_o,
  output logic        beat_rw_o,
  output logic        wb_valid_o,
  output logic [3:0]  wb_reg_o,
  output logic [31:0] wb_data_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  state_dbg
);

  // Beat handshake: a beat transfers on a cycle where beat_valid_o and
  // beat_ready_i are both high; while ready is low every beat output holds.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        load_q, up_q, pre_q, empty_q;
  logic [3:0]  base_reg_q;
  logic [31:0] base_q, addr_q;
  logic [15:0] list_q, list_rest;
  logic [4:0]  n_cnt;
  logic [31:0] span, first_addr;
  logic [3:0]  low_idx;

`ifdef LDM_STM_SEQ_WB_EN
  logic        wb_q, wb_ok_q;
  logic [31:0] final_q;
`else
  logic        wb_unused;
  assign wb_unused = wb_i;
`endif

  always_comb begin
    n_cnt = 5'd0;
    for (int k = 0; k < 16; k++) n_cnt = n_cnt + {4'd0, list_q[k]};
  end

  assign span = {25'd0, n_cnt, 2'b00};

  // Registers always go out ascending, so a decrementing transfer starts at the low end.
  always_comb begin
    first_addr = base_q;
    case ({up_q, pre_q})
      2'b10:   first_addr = base_q;
      2'b11:   first_addr = base_q + 32'd4;
      2'b00:   first_addr = base_q - span + 32'd4;
      default: first_addr = base_q - span;
    endcase
  end

  assign list_rest = list_q & (list_q - 16'd1);

  always_comb begin
    low_idx = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (list_q[k]) low_idx = 4'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_SETUP;
      S_SETUP: state_d = (n_cnt == 5'd0) ? S_FIN : S_XFER;
      S_XFER:  if (beat_ready_i && (list_rest == 16'd0)) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      load_q     <= 1'b0;
      up_q       <= 1'b0;
      pre_q      <= 1'b0;
      empty_q    <= 1'b0;
      base_reg_q <= 4'd0;
      base_q     <= 32'd0;
      addr_q     <= 32'd0;
      list_q     <= 16'd0;
`ifdef LDM_STM_SEQ_WB_EN
      wb_q       <= 1'b0;
      wb_ok_q    <= 1'b0;
      final_q    <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            load_q     <= load_i;
            up_q       <= up_i;
            pre_q      <= pre_i;
            base_reg_q <= base_reg_i;
            base_q     <= {base_i[31:2], 2'b00};
            list_q     <= reg_list_i;
`ifdef LDM_STM_SEQ_WB_EN
            wb_q       <= wb_i;
`endif
          end
        end
        S_SETUP: begin
          addr_q  <= first_addr;
          empty_q <= (n_cnt == 5'd0);
`ifdef LDM_STM_SEQ_WB_EN
          final_q <= up_q ? (base_q + span) : (base_q - span);
          // A loaded Rn takes precedence over the writeback of the base.
          wb_ok_q <= wb_q && (n_cnt != 5'd0) && !(load_q && list_q[base_reg_q]);
`endif
        end
        S_XFER: begin
          if (beat_ready_i) begin
            list_q <= list_rest;
            addr_q <= addr_q + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign beat_valid_o = (state_q == S_XFER);
  assign beat_reg_o   = low_idx;
  assign beat_addr_o  = addr_q;
  assign beat_rw_o    = load_q;
  assign done_o       = (state_q == S_FIN);
  assign err_o        = (state_q == S_FIN) && empty_q;
  assign wb_reg_o     = base_reg_q;
  assign state_dbg    = state_q;

`ifdef LDM_STM_SEQ_WB_EN
  assign wb_valid_o = (state_q == S_FIN) && wb_ok_q;
  assign wb_data_o  = final_q;
`else
  assign wb_valid_o = 1'b0;
  assign wb_data_o  = 32'd0;
`endif

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: vector table of transfers plus stall and reset sequences.
module tb_ldm_stm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, load_i, up_i, pre_i, wb_i;
  logic [3:0]  base_reg_i;
  logic [31:0] base_i;
  logic [15:0] reg_list_i;
  logic        busy_o, beat_valid_o, beat_ready_i, beat_rw_o;
  logic [3:0]  beat_reg_o, wb_reg_o;
  logic [31:0] beat_addr_o, wb_data_o;
  logic        wb_valid_o, done_o, err_o;
  logic [1:0]  state_dbg;

  typedef struct {
    logic        load;
    logic        up;
    logic        pre;
    logic        wb;
    logic [3:0]  rn;
    logic [31:0] base;
    logic [15:0] list;
    logic [31:0] first;
    logic [31:0] fin;
    logic        wbv;
  } vec_t;

  vec_t        vecs[9];
  logic [35:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cur_id = 0;

  ldm_stm_seq dut (
    .clk(clk), .rst(rst), .start_i(start_i), .load_i(load_i), .up_i(up_i),
    .pre_i(pre_i), .wb_i(wb_i), .base_reg_i(base_reg_i), .base_i(base_i),
    .reg_list_i(reg_list_i), .busy_o(busy_o), .beat_valid_o(beat_valid_o),
    .beat_ready_i(beat_ready_i), .beat_reg_o(beat_reg_o), .beat_addr_o(beat_addr_o),
    .beat_rw_o(beat_rw_o), .wb_valid_o(wb_valid_o), .wb_reg_o(wb_reg_o),
    .wb_data_o(wb_data_o), .done_o(done_o), .err_o(err_o), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (case %0d): got %0h expected %0h", name, cur_id, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {35'd0, busy_o}, 36'd0);
    check({tag, "_valid"}, {35'd0, beat_valid_o}, 36'd0);
    check({tag, "_beat"}, {beat_reg_o, beat_addr_o}, 36'd0);
    check({tag, "_rw"}, {35'd0, beat_rw_o}, 36'd0);
    check({tag, "_done_err"}, {34'd0, done_o, err_o}, 36'd0);
    check({tag, "_wb"}, {wb_valid_o, wb_reg_o, wb_data_o[30:0]}, 36'd0);
    check({tag, "_wbd31_state"}, {33'd0, wb_data_o[31], state_dbg}, 36'd0);
  endtask

  task automatic drive_start(input vec_t v);
    load_i = v.load; up_i = v.up; pre_i = v.pre; wb_i = v.wb;
    base_reg_i = v.rn; base_i = v.base; reg_list_i = v.list;
    start_i = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] a;
    logic [35:0] e;
    logic        exp_wbv;
    logic [31:0] exp_wbd;
    exp_q.delete();
    a = v.first;
    for (int k = 0; k < 16; k++) begin
      if (v.list[k]) begin
        exp_q.push_back({4'(k), a});
        a = a + 32'd4;
      end
    end
`ifdef LDM_STM_SEQ_WB_EN
    exp_wbv = v.wbv;
    exp_wbd = v.fin;
`else
    exp_wbv = 1'b0;
    exp_wbd = 32'd0;
`endif
    @(negedge clk);
    drive_start(v);
    @(negedge clk);
    start_i = 1'b0;
    check("setup_busy", {35'd0, busy_o}, 36'd1);
    check("setup_valid", {35'd0, beat_valid_o}, 36'd0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("beat_valid", {35'd0, beat_valid_o}, 36'd1);
      check("beat", {beat_reg_o, beat_addr_o}, e);
      check("beat_rw", {35'd0, beat_rw_o}, {35'd0, v.load});
      check("beat_done", {35'd0, done_o}, 36'd0);
    end
    @(negedge clk);
    check("fin_done", {35'd0, done_o}, 36'd1);
    check("fin_err", {35'd0, err_o}, {35'd0, (v.list == 16'd0)});
    check("fin_valid", {35'd0, beat_valid_o}, 36'd0);
    check("fin_wb_valid", {35'd0, wb_valid_o}, {35'd0, exp_wbv});
    check("fin_wb_reg", {32'd0, wb_reg_o}, {32'd0, v.rn});
    if (exp_wbv || (exp_wbd == 32'd0 && !v.wbv))
      check("fin_wb_data", {4'd0, wb_data_o}, {4'd0, exp_wbd});
    @(negedge clk);
    check("idle_busy", {35'd0, busy_o}, 36'd0);
    check("idle_done_wb", {34'd0, done_o, wb_valid_o}, 36'd0);
  endtask

  initial begin
    //          load  up    pre   wb    rn     base           list       first          fin            wbv
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd4,  32'h0000_0100, 16'h000E, 32'h0000_0100, 32'h0000_010C, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 32'h0000_0200, 16'h8001, 32'h0000_01F8, 32'h0000_01F8, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  32'h0000_0300, 16'h0004, 32'h0000_0300, 32'h0000_0304, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd3,  32'h0000_0400, 16'h0000, 32'h0000_0400, 32'h0000_0400, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd6,  32'hFFFF_FFF8, 16'h0003, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  32'h0000_1003, 16'h0F00, 32'h0000_0FF4, 32'h0000_0FF0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd1,  32'h0000_0020, 16'h0006, 32'h0000_0020, 32'h0000_0028, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd5,  32'h0000_0004, 16'h0003, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 32'h0000_0000, 16'hFFFF, 32'h0000_0000, 32'h0000_0040, 1'b0};

    rst = 1'b0; start_i = 1'b0; load_i = 1'b0; up_i = 1'b0; pre_i = 1'b0; wb_i = 1'b0;
    base_reg_i = 4'd0; base_i = 32'd0; reg_list_i = 16'd0; beat_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cur_id = i;
      run_vec(vecs[i]);
    end

    // Stall: ready low for three cycles on beat 0, with a stray start during XFER.
    cur_id = 100;
    @(negedge clk);
    drive_start('{1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 32'h0000_0500, 16'h0003,
                  32'd0, 32'd0, 1'b0});
    @(negedge clk);                       // SETUP
    start_i = 1'b0;
    beat_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_valid", {35'd0, beat_valid_o}, 36'd1);
      check("stall_beat0", {beat_reg_o, beat_addr_o}, {4'd0, 32'h0000_0500});
      check("stall_done", {35'd0, done_o}, 36'd0);
      if (c == 1) begin
        drive_start('{1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 32'h0000_9000, 16'h00F0,
                      32'd0, 32'd0, 1'b0});
      end else begin
        start_i = 1'b0;
      end
      if (c == 3) beat_ready_i = 1'b1;
    end
    @(negedge clk);
    check("stall_beat1", {beat_reg_o, beat_addr_o}, {4'd1, 32'h0000_0504});
    check("stall_rw", {35'd0, beat_rw_o}, 36'd0);
    @(negedge clk);
    check("stall_fin", {34'd0, done_o, err_o}, 36'd2);
    @(negedge clk);
    check("stall_idle", {34'd0, busy_o, beat_valid_o}, 36'd0);
    check("stall_state", {34'd0, state_dbg}, 36'd0);

    // Reset asserted during the first beat of a wrapping IB transfer.
    cur_id = 200;
    @(negedge clk);
    drive_start(vecs[4]);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check("rst_pre_beat", {beat_reg_o, beat_addr_o}, {4'd0, 32'hFFFF_FFFC});
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    cur_id = 300;
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
